// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//   Memory stage that sits right after the ALU. The ALU result is the
//   effective address and rs2 is the store data. Each accepted request runs
//   one RV32I load or store over a req/ack data bus, steers store bytes onto
//   the right lanes, sign/zero-extends load data and reports completion to
//   writeback with a one-cycle done pulse plus a fault code.
//
// Parameters
//   TIMEOUT    cycles mem_req may stay high without mem_ack before aborting
//
// Ports
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   start              request strobe, only looked at while idle
//   isLoad, isStore    instruction class (exactly one must be set)
//   funct3             access width / signedness
//   addr, wdata        effective address and store data
//   busy, done         transaction in flight / one-cycle completion pulse
//   rdata, fault       extended load result and cause (00 ok, 01 misaligned,
//                      10 illegal, 11 timeout), both valid with done
//   mem_req, mem_we    bus request and direction
//   mem_addr           word-aligned bus address
//   mem_wdata          lane-replicated store data
//   mem_wstrb          byte enables (0000 on reads)
//   mem_ack, mem_rdata bus completion and read word
// ---------------------------------------------------------------------------
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        isLoad,
    input  logic        isStore,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic [1:0]  fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic          op_load;
    logic [2:0]    op_funct3;
    logic [1:0]    op_lane;

    logic          valid_op;
    logic          illegal;
    logic          misaligned;
    logic [3:0]    st_strb;
    logic [31:0]   st_data;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   ld_value;

    // Request decode on the raw inputs; only meaningful in IDLE.
    // Illegal encodings take priority over alignment checks.
    assign valid_op   = isLoad ^ isStore;
    assign illegal    = isLoad ? ((funct3 == 3'b011) || (funct3[2:1] == 2'b11))
                               : (funct3 >= 3'b011);
    assign misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                        ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));

    // Store lane steering: data is replicated across lanes so the strobe
    // alone selects which bytes the memory actually writes.
    always_comb begin
        st_strb = 4'b0000;
        st_data = wdata;
        case (funct3[1:0])
            2'b00: begin
                st_strb = 4'b0001 << addr[1:0];
                st_data = {4{wdata[7:0]}};
            end
            2'b01: begin
                st_strb = addr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{wdata[15:0]}};
            end
            2'b10: begin
                st_strb = 4'b1111;
                st_data = wdata;
            end
            default: begin
                st_strb = 4'b0000;
                st_data = wdata;
            end
        endcase
    end

    // Load extraction uses the byte offset and funct3 latched at start,
    // since the request inputs are free to change once we are busy.
    assign ld_byte = mem_rdata[{op_lane, 3'b000} +: 8];
    assign ld_half = mem_rdata[{op_lane[1], 4'b0000} +: 16];

    always_comb begin
        ld_value = 32'h0;
        case (op_funct3)
            3'b000:  ld_value = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_value = {{16{ld_half[15]}}, ld_half};
            3'b010:  ld_value = mem_rdata;
            3'b100:  ld_value = {24'h0, ld_byte};
            3'b101:  ld_value = {16'h0, ld_half};
            default: ld_value = 32'h0;
        endcase
    end

    // Main controller. done is raised on the way out of RESP, so the cycle
    // carrying done is already IDLE; a start seen while done is high is
    // dropped so the earliest new request is the cycle after completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            rdata     <= 32'h0;
            fault     <= 2'b00;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            mem_wstrb <= 4'b0000;
            count     <= '0;
            op_load   <= 1'b0;
            op_funct3 <= 3'b000;
            op_lane   <= 2'b00;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && valid_op && !done) begin
                        busy      <= 1'b1;
                        rdata     <= 32'h0;
                        fault     <= 2'b00;
                        count     <= '0;
                        op_load   <= isLoad;
                        op_funct3 <= funct3;
                        op_lane   <= addr[1:0];
                        if (illegal) begin
                            fault <= 2'b10;
                            state <= RESP;
                        end else if (misaligned) begin
                            fault <= 2'b01;
                            state <= RESP;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= isStore;
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_wdata <= isStore ? st_data : 32'h0;
                            mem_wstrb <= isStore ? st_strb : 4'b0000;
                            state     <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (op_load) begin
                            rdata <= ld_value;
                        end
                        state <= RESP;
                    end else if (count == LAST) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        fault   <= 2'b11;
                        state   <= RESP;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                RESP: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
//   Directed bench for load_store_unit. A small bus responder either follows
//   a manually driven ack/read word or, in auto mode, acks in the same cycle
//   as the request from a 16-word memory.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_load;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic [1:0]  fault;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic        auto_ack;
    logic        man_ack;
    logic [31:0] man_rdata;
    logic [31:0] mem [0:15];

    int checks = 0;
    int errors = 0;

    load_store_unit #(.TIMEOUT(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .isLoad    (is_load),
        .isStore   (is_store),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .rdata     (rdata),
        .fault     (fault),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Bus responder: same-cycle ack from the memory in auto mode.
    assign mem_ack   = auto_ack ? mem_req : man_ack;
    assign mem_rdata = auto_ack ? mem[mem_addr[5:2]] : man_rdata;

    // Byte-strobed memory writes on a completed write beat.
    always @(posedge clk) begin
        if (auto_ack && mem_req && mem_ack && mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wstrb[b]) begin
                    mem[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present one request for a single cycle; returns in the cycle after start.
    task automatic applyStimulus(input logic ld, input logic st, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] wd);
        start    = 1'b1;
        is_load  = ld;
        is_store = st;
        funct3   = f3;
        addr     = a;
        wdata    = wd;
        tick();
        start    = 1'b0;
    endtask

    // Wait for done; lat is cycles since start, req_cycles counts mem_req highs.
    task automatic waitDone(input int max_cycles, output int lat, output int req_cycles);
        lat        = 1;
        req_cycles = mem_req ? 1 : 0;
        while (!done && lat < max_cycles) begin
            tick();
            lat++;
            if (mem_req) req_cycles++;
        end
    endtask

    initial begin
        int lat;
        int reqc;
        int done_cnt;

        rst       = 1'b1;
        start     = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        funct3    = 3'b000;
        addr      = 32'h0;
        wdata     = 32'h0;
        auto_ack  = 1'b0;
        man_ack   = 1'b0;
        man_rdata = 32'h0;
        tick();
        tick();

        checkOutput("rst_busy",  busy,      0);
        checkOutput("rst_done",  done,      0);
        checkOutput("rst_req",   mem_req,   0);
        checkOutput("rst_we",    mem_we,    0);
        checkOutput("rst_rdata", rdata,     0);
        checkOutput("rst_fault", fault,     0);
        checkOutput("rst_addr",  mem_addr,  0);
        checkOutput("rst_wstrb", mem_wstrb, 0);
        rst = 1'b0;
        tick();

        // start with both or neither class set is ignored
        applyStimulus(1, 1, 3'b010, 32'h0, 32'h0);
        checkOutput("both_busy", busy, 0);
        applyStimulus(0, 0, 3'b010, 32'h0, 32'h0);
        checkOutput("none_busy", busy, 0);
        checkOutput("none_req", mem_req, 0);

        // SB to byte 3, ack two cycles after req rises
        applyStimulus(0, 1, 3'b000, 32'h0000_1003, 32'hAABB_CCDD);
        checkOutput("sb_req",   mem_req,   1);
        checkOutput("sb_busy",  busy,      1);
        checkOutput("sb_we",    mem_we,    1);
        checkOutput("sb_addr",  mem_addr,  32'h0000_1000);
        checkOutput("sb_strb",  mem_wstrb, 4'b1000);
        checkOutput("sb_wdata", mem_wdata, 32'hDDDD_DDDD);
        tick();
        checkOutput("sb_hold",  mem_req, 1);
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        checkOutput("sb_drop",  mem_req, 0);
        tick();
        checkOutput("sb_done",  done,  1);
        checkOutput("sb_busyd", busy,  0);
        checkOutput("sb_fault", fault, 2'b00);
        checkOutput("sb_rdata", rdata, 0);
        tick();
        checkOutput("sb_pulse", done, 0);

        // loads from 0x12F45678 with ack held high
        man_rdata = 32'h12F4_5678;
        man_ack   = 1'b1;
        applyStimulus(1, 0, 3'b000, 32'h0000_2002, 32'h0);
        checkOutput("lb_we", mem_we, 0);
        checkOutput("lb_strb", mem_wstrb, 0);
        waitDone(30, lat, reqc);
        checkOutput("lb_lat",   lat,   3);
        checkOutput("lb_rdata", rdata, 32'hFFFF_FFF4);
        tick();
        applyStimulus(1, 0, 3'b100, 32'h0000_2002, 32'h0);
        waitDone(30, lat, reqc);
        checkOutput("lbu_rdata", rdata, 32'h0000_00F4);
        tick();
        applyStimulus(1, 0, 3'b101, 32'h0000_2002, 32'h0);
        waitDone(30, lat, reqc);
        checkOutput("lhu_rdata", rdata, 32'h0000_12F4);
        tick();
        applyStimulus(1, 0, 3'b001, 32'h0000_2000, 32'h0);
        waitDone(30, lat, reqc);
        checkOutput("lh_rdata", rdata, 32'h0000_5678);
        tick();
        applyStimulus(1, 0, 3'b000, 32'h0000_2001, 32'h0);
        waitDone(30, lat, reqc);
        checkOutput("lb1_rdata", rdata, 32'h0000_0056);
        tick();
        man_rdata = 32'h8001_0000;
        applyStimulus(1, 0, 3'b001, 32'h0000_2002, 32'h0);
        waitDone(30, lat, reqc);
        checkOutput("lh_neg", rdata, 32'hFFFF_8001);
        man_ack = 1'b0;
        tick();

        // misaligned LW: no bus activity, done at start+2
        applyStimulus(1, 0, 3'b010, 32'h0000_2001, 32'h0);
        checkOutput("mis_busy", busy, 1);
        checkOutput("mis_req",  mem_req, 0);
        waitDone(30, lat, reqc);
        checkOutput("mis_lat",   lat,   2);
        checkOutput("mis_reqc",  reqc,  0);
        checkOutput("mis_fault", fault, 2'b01);
        checkOutput("mis_rdata", rdata, 0);
        tick();

        // misaligned SH
        applyStimulus(0, 1, 3'b001, 32'h0000_1001, 32'h0);
        waitDone(30, lat, reqc);
        checkOutput("missh_fault", fault, 2'b01);
        checkOutput("missh_reqc",  reqc,  0);
        tick();

        // illegal load and store encodings
        applyStimulus(1, 0, 3'b011, 32'h0000_2000, 32'h0);
        waitDone(30, lat, reqc);
        checkOutput("ill_lat",   lat,   2);
        checkOutput("ill_fault", fault, 2'b10);
        checkOutput("ill_reqc",  reqc,  0);
        tick();
        applyStimulus(0, 1, 3'b011, 32'h0000_2000, 32'h0);
        waitDone(30, lat, reqc);
        checkOutput("ills_fault", fault, 2'b10);
        tick();

        // timeout: ack never arrives
        applyStimulus(1, 0, 3'b010, 32'h0000_3000, 32'h0);
        waitDone(40, lat, reqc);
        checkOutput("to_reqc",  reqc,  16);
        checkOutput("to_lat",   lat,   18);
        checkOutput("to_done",  done,  1);
        checkOutput("to_fault", fault, 2'b11);
        checkOutput("to_rdata", rdata, 0);
        tick();

        // start pulsed while busy, in RESP and in the done cycle
        man_rdata = 32'h1234_5678;
        applyStimulus(1, 0, 3'b010, 32'h0000_2000, 32'h0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        start   = 1'b1;
        tick();
        checkOutput("ign_done",  done,  1);
        checkOutput("ign_rdata", rdata, 32'h1234_5678);
        tick();
        start = 1'b0;
        checkOutput("ign_busy", busy, 0);
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) done_cnt++;
            tick();
        end
        checkOutput("ign_extra", done_cnt, 0);

        // reset mid-REQ drops mem_req at once; late ack ignored
        applyStimulus(1, 0, 3'b010, 32'h0000_2000, 32'h0);
        tick();
        checkOutput("rr_req", mem_req, 1);
        rst = 1'b1;
        #1;
        checkOutput("rr_drop", mem_req, 0);
        checkOutput("rr_busy", busy, 0);
        tick();
        rst     = 1'b0;
        man_ack = 1'b1;
        tick();
        tick();
        man_ack  = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (done) done_cnt++;
            tick();
        end
        checkOutput("rr_nodone", done_cnt, 0);

        // auto-ack: SH lane check, then back-to-back SW/LW
        auto_ack = 1'b1;
        applyStimulus(0, 1, 3'b001, 32'h0000_1002, 32'h1122_3344);
        checkOutput("sh_strb",  mem_wstrb, 4'b1100);
        checkOutput("sh_wdata", mem_wdata, 32'h3344_3344);
        waitDone(30, lat, reqc);
        checkOutput("sh_lat", lat, 3);
        tick();
        applyStimulus(0, 1, 3'b010, 32'h0000_0040, 32'hCAFE_F00D);
        checkOutput("sw_strb", mem_wstrb, 4'b1111);
        waitDone(30, lat, reqc);
        checkOutput("sw_lat",   lat,   3);
        checkOutput("sw_fault", fault, 2'b00);
        tick();
        applyStimulus(1, 0, 3'b010, 32'h0000_0040, 32'h0);
        waitDone(30, lat, reqc);
        checkOutput("lw_lat",   lat,   3);
        checkOutput("lw_rdata", rdata, 32'hCAFE_F00D);
        checkOutput("lw_fault", fault, 2'b00);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
